// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter: FSM states,
// access owner encoding and counter width derivation.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   // Bits needed for a counter that must be able to hold max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
   parameter int MAX_VAL = 4,
   parameter int W       = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_Q = W'(MAX_VAL);

   // Count up to MAX_VAL and stick there until cleared.
   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_Q)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the CPU datapath and
// the program loader. Fixed CPU priority, with a burst bound so a waiting
// loader is served after at most MAX_BURST consecutive CPU accesses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 1,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_done,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   output logic              mem_memread,
   output logic              mem_memwrite,
   input  logic [DATA_W-1:0] mem_out32
);

   localparam int LAT_W   = cnt_width(MEM_LAT);
   localparam int BURST_W = cnt_width(MAX_BURST);

   arb_state_t         state, state_nxt;
   owner_t             owner, owner_sel;
   logic               we_q;
   logic               start;
   logic               last_busy;
   logic               burst_full;
   logic               burst_inc, burst_clr;
   logic [LAT_W-1:0]   lat_cnt;
   logic [BURST_W-1:0] burst_cnt;

   assign burst_full = (burst_cnt == BURST_W'(MAX_BURST));

   // Counts consecutive CPU wins while the loader is kept waiting.
   arb_sat_counter #(.MAX_VAL(MAX_BURST), .W(BURST_W)) u_burst_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (burst_clr),
      .inc   (burst_inc),
      .count (burst_cnt)
   );

   // Counts cycles spent in BUSY; idle at zero outside BUSY.
   arb_sat_counter #(.MAX_VAL(MEM_LAT), .W(LAT_W)) u_lat_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (state != BUSY),
      .inc   (state == BUSY),
      .count (lat_cnt)
   );

   // Next-state, owner selection and burst counter control.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      owner_sel = OWN_CPU;
      start     = 1'b0;
      burst_inc = 1'b0;
      burst_clr = 1'b0;
      last_busy = (state == BUSY) && (lat_cnt == LAT_W'(MEM_LAT - 1));
      case (state)
         IDLE: begin
            if (cpu_req || ldr_req) begin
               start     = 1'b1;
               state_nxt = BUSY;
               if (!cpu_req || (ldr_req && burst_full)) begin
                  owner_sel = OWN_LDR;
               end
            end
            burst_clr = !ldr_req || (start && (owner_sel == OWN_LDR));
            burst_inc = start && (owner_sel == OWN_CPU) && ldr_req;
         end
         BUSY: begin
            if (last_busy) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, grant pulses and the latched winning request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         owner         <= OWN_CPU;
         we_q          <= 1'b0;
         mem_address   <= '0;
         mem_writeData <= '0;
         cpu_gnt       <= 1'b0;
         ldr_gnt       <= 1'b0;
      end else begin
         state   <= state_nxt;
         cpu_gnt <= start && (owner_sel == OWN_CPU);
         ldr_gnt <= start && (owner_sel == OWN_LDR);
         if (start) begin
            owner         <= owner_sel;
            we_q          <= (owner_sel == OWN_LDR) ? ldr_we    : cpu_we;
            mem_address   <= (owner_sel == OWN_LDR) ? ldr_addr  : cpu_addr;
            mem_writeData <= (owner_sel == OWN_LDR) ? ldr_wdata : cpu_wdata;
         end
      end
   end

   // Capture read data into the owner's register at the end of the last BUSY cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rdata <= '0;
         ldr_rdata <= '0;
      end else if (last_busy && !we_q) begin
         if (owner == OWN_CPU) begin
            cpu_rdata <= mem_out32;
         end else begin
            ldr_rdata <= mem_out32;
         end
      end
   end

   assign mem_memread  = (state == BUSY) && !we_q;
   assign mem_memwrite = (state == BUSY) && we_q;
   assign cpu_done     = (state == DONE) && (owner == OWN_CPU);
   assign ldr_done     = (state == DONE) && (owner == OWN_LDR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) checked
// every cycle against a transaction-timeline model, plus directed scenarios
// with hand-computed expectations and a randomized requester phase.
module tb_mem_port_arbiter;

   localparam int NI   = 2;
   localparam int MAXB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req   [NI][2];
   logic        we    [NI][2];
   logic [31:0] addr  [NI][2];
   logic [31:0] wdata [NI][2];
   logic [31:0] mem_out [NI];

   wire         gnt   [NI][2];
   wire         done  [NI][2];
   wire  [31:0] rdata [NI][2];
   wire  [31:0] m_addr_w [NI];
   wire  [31:0] m_wd_w   [NI];
   wire         m_rd [NI];
   wire         m_wr [NI];

   for (genvar k = 0; k < NI; k++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W(32), .DATA_W(32), .MEM_LAT(k == 0 ? 1 : 3), .MAX_BURST(MAXB)
      ) u_dut (
         .clk           (clk),
         .reset         (reset),
         .cpu_req       (req[k][0]),
         .cpu_we        (we[k][0]),
         .cpu_addr      (addr[k][0]),
         .cpu_wdata     (wdata[k][0]),
         .cpu_gnt       (gnt[k][0]),
         .cpu_done      (done[k][0]),
         .cpu_rdata     (rdata[k][0]),
         .ldr_req       (req[k][1]),
         .ldr_we        (we[k][1]),
         .ldr_addr      (addr[k][1]),
         .ldr_wdata     (wdata[k][1]),
         .ldr_gnt       (gnt[k][1]),
         .ldr_done      (done[k][1]),
         .ldr_rdata     (rdata[k][1]),
         .mem_address   (m_addr_w[k]),
         .mem_writeData (m_wd_w[k]),
         .mem_memread   (m_rd[k]),
         .mem_memwrite  (m_wr[k]),
         .mem_out32     (mem_out[k])
      );
   end

   // Model: the access in flight is described by its sample cycle and fields.
   bit          m_busy  [NI];
   int          m_ts    [NI];
   bit          m_own   [NI];
   bit          m_we    [NI];
   logic [31:0] m_addr  [NI];
   logic [31:0] m_wd    [NI];
   logic [31:0] m_rdata [NI][2];
   int          m_burst [NI];

   int total;
   int bad;
   int cyc;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic check_bit(input string name, input int k, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] cyc=%0d got=%b want=%b", name, k, cyc, act, exp);
      end
   endtask

   task automatic check_word(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_busy[k]     = 1'b0;
      m_ts[k]       = 0;
      m_own[k]      = 1'b0;
      m_we[k]       = 1'b0;
      m_addr[k]     = '0;
      m_wd[k]       = '0;
      m_rdata[k][0] = '0;
      m_rdata[k][1] = '0;
      m_burst[k]    = 0;
   endtask

   // Compare this cycle's outputs to the model, then advance the model with
   // the inputs that the coming clock edge will sample.
   task automatic model_cycle();
      int    l;
      int    ph;
      bit    in_txn;
      bit    strobe;
      bit    cr, lr, own;
      string rn;
      for (int k = 0; k < NI; k++) begin
         l      = lat_of(k);
         ph     = cyc - m_ts[k];
         in_txn = m_busy[k] && (ph >= 1) && (ph <= l + 1);
         strobe = in_txn && (ph <= l);
         for (int r = 0; r < 2; r++) begin
            rn = (r == 0) ? "cpu" : "ldr";
            check_bit({rn, "_gnt"}, k, gnt[k][r], in_txn && (ph == 1) && (m_own[k] == r[0]));
            check_bit({rn, "_done"}, k, done[k][r], in_txn && (ph == l + 1) && (m_own[k] == r[0]));
            check_word({rn, "_rdata"}, k, rdata[k][r], m_rdata[k][r]);
         end
         check_bit("mem_memread", k, m_rd[k], strobe && !m_we[k]);
         check_bit("mem_memwrite", k, m_wr[k], strobe && m_we[k]);
         check_word("mem_address", k, m_addr_w[k], m_addr[k]);
         check_word("mem_writeData", k, m_wd_w[k], m_wd[k]);

         if (reset) begin
            model_reset(k);
         end else begin
            if (strobe && (ph == l) && !m_we[k]) begin
               m_rdata[k][m_own[k]] = mem_out[k];
            end
            if (!in_txn) begin
               cr  = req[k][0];
               lr  = req[k][1];
               own = !cr || (lr && (m_burst[k] == MAXB));
               if (cr || lr) begin
                  m_busy[k] = 1'b1;
                  m_ts[k]   = cyc;
                  m_own[k]  = own;
                  m_we[k]   = we[k][own];
                  m_addr[k] = addr[k][own];
                  m_wd[k]   = wdata[k][own];
               end
               if (!lr || own) begin
                  m_burst[k] = 0;
               end else if (m_burst[k] < MAXB) begin
                  m_burst[k] = m_burst[k] + 1;
               end
            end
         end
      end
   endtask

   // One clock: compare at the falling edge, return 1 time unit after the rising edge.
   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic quiet(input int k);
      check_bit("rst_cpu_gnt", k, gnt[k][0], 1'b0);
      check_bit("rst_ldr_gnt", k, gnt[k][1], 1'b0);
      check_bit("rst_cpu_done", k, done[k][0], 1'b0);
      check_bit("rst_ldr_done", k, done[k][1], 1'b0);
      check_bit("rst_memread", k, m_rd[k], 1'b0);
      check_bit("rst_memwrite", k, m_wr[k], 1'b0);
      check_word("rst_mem_address", k, m_addr_w[k], 32'h0);
   endtask

   // Issue one access, follow it to its done pulse plus one idle cycle.
   task automatic access(input int k, input int r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         output int n_rd, output int n_wr, output int n_done,
                         output int gnt_at, output int done_at,
                         output logic [31:0] addr_seen, output logic [31:0] wd_seen);
      n_rd = 0; n_wr = 0; n_done = 0; gnt_at = -1; done_at = -1;
      addr_seen = '0; wd_seen = '0;
      req[k][r] = 1'b1; we[k][r] = w; addr[k][r] = a; wdata[k][r] = d;
      for (int i = 1; (i <= 20) && ((done_at < 0) || (i <= done_at + 1)); i++) begin
         tick();
         if (gnt[k][r]) gnt_at = i;
         if (m_rd[k]) begin n_rd++; addr_seen = m_addr_w[k]; end
         if (m_wr[k]) begin n_wr++; addr_seen = m_addr_w[k]; wd_seen = m_wd_w[k]; end
         if (done[k][r]) begin n_done++; done_at = i; req[k][r] = 1'b0; end
      end
      req[k][r] = 1'b0;
   endtask

   task automatic new_req(input int k, input int r);
      req[k][r]   = 1'b1;
      we[k][r]    = 1'($urandom_range(1, 0));
      addr[k][r]  = $urandom();
      wdata[k][r] = $urandom();
   endtask

   initial begin
      int          n_rd, n_wr, n_done, gnt_at, done_at, n_g, n_both, g1, g2;
      logic [31:0] a_seen, d_seen;
      logic [9:0]  exp_order, got_order;

      total = 0; bad = 0; cyc = 0;
      reset = 1'b1;
      for (int k = 0; k < NI; k++) begin
         model_reset(k);
         mem_out[k] = '0;
         for (int r = 0; r < 2; r++) begin
            req[k][r] = 1'b1; we[k][r] = 1'b0; addr[k][r] = 32'h44; wdata[k][r] = '0;
         end
      end
      @(posedge clk);
      #1;
      cyc = 1;

      // Reset held two cycles with both requests high, then released.
      for (int k = 0; k < NI; k++) quiet(k);
      tick();
      reset = 1'b0;
      for (int k = 0; k < NI; k++) begin
         req[k][0] = 1'b0;
         req[k][1] = 1'b0;
      end
      for (int k = 0; k < NI; k++) quiet(k);
      tick();

      // MEM_LAT=1 CPU read.
      mem_out[0] = 32'hDEADBEEF;
      access(0, 0, 1'b0, 32'h10, 32'h0, n_rd, n_wr, n_done, gnt_at, done_at, a_seen, d_seen);
      check_word("t2_gnt_at", 0, gnt_at, 32'd1);
      check_word("t2_rd_cycles", 0, n_rd, 32'd1);
      check_word("t2_rd_addr", 0, a_seen, 32'h10);
      check_word("t2_done_at", 0, done_at, 32'd2);
      check_word("t2_rdata", 0, rdata[0][0], 32'hDEADBEEF);

      // Loader write must not disturb previously read loader data.
      mem_out[0] = 32'hA5A5A5A5;
      access(0, 1, 1'b0, 32'h40, 32'h0, n_rd, n_wr, n_done, gnt_at, done_at, a_seen, d_seen);
      check_word("t3_pre_rdata", 0, rdata[0][1], 32'hA5A5A5A5);
      mem_out[0] = 32'h11111111;
      access(0, 1, 1'b1, 32'h20, 32'h00001234, n_rd, n_wr, n_done, gnt_at, done_at, a_seen, d_seen);
      check_word("t3_wr_cycles", 0, n_wr, 32'd1);
      check_word("t3_rd_cycles", 0, n_rd, 32'd0);
      check_word("t3_wdata", 0, d_seen, 32'h00001234);
      check_word("t3_addr", 0, a_seen, 32'h20);
      check_word("t3_done_count", 0, n_done, 32'd1);
      check_word("t3_rdata", 0, rdata[0][1], 32'hA5A5A5A5);

      // Both requesters hold req: burst bound forces every fifth grant to the loader.
      exp_order = 10'b1000010000;
      got_order = '0;
      n_g = 0; n_both = 0;
      req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 32'h100;
      req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 32'h200;
      for (int i = 0; (i < 60) && (req[0][0] || req[0][1]); i++) begin
         tick();
         if (gnt[0][0] && gnt[0][1]) n_both++;
         if ((gnt[0][0] || gnt[0][1]) && (n_g < 10)) begin
            got_order[n_g] = gnt[0][1];
            n_g++;
         end
         for (int r = 0; r < 2; r++) begin
            if ((n_g >= 10) && done[0][r]) req[0][r] = 1'b0;
         end
      end
      req[0][0] = 1'b0; req[0][1] = 1'b0;
      check_word("t4_grants", 0, n_g, 32'd10);
      check_word("t4_order", 0, {22'd0, got_order}, {22'd0, exp_order});
      check_word("t4_double_gnt", 0, n_both, 32'd0);
      tick();

      // MEM_LAT=3 CPU read aborted by reset in its second BUSY cycle.
      mem_out[1] = 32'h55555555;
      req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 32'h30;
      n_done = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (done[1][0]) n_done++;
         if (i == 1) check_bit("t5_inflight_read", 1, m_rd[1], 1'b1);
         if (i == 2) reset = 1'b1;
         if (i == 3) begin
            check_bit("t5_read_after_reset", 1, m_rd[1], 1'b0);
            reset = 1'b0;
            req[1][0] = 1'b0;
         end
      end
      check_word("t5_no_done", 1, n_done, 32'd0);
      mem_out[1] = 32'h0BADCAFE;
      access(1, 0, 1'b0, 32'h34, 32'h0, n_rd, n_wr, n_done, gnt_at, done_at, a_seen, d_seen);
      check_word("t5_regrant_at", 1, gnt_at, 32'd1);
      check_word("t5_redone_at", 1, done_at, 32'd4);
      check_word("t5_rdata", 1, rdata[1][0], 32'h0BADCAFE);

      // MEM_LAT=3 loader read, then back-to-back grant spacing.
      mem_out[1] = 32'hCAFEF00D;
      access(1, 1, 1'b0, 32'h50, 32'h0, n_rd, n_wr, n_done, gnt_at, done_at, a_seen, d_seen);
      check_word("t6_rd_cycles", 1, n_rd, 32'd3);
      check_word("t6_done_at", 1, done_at, 32'd4);
      check_word("t6_rdata", 1, rdata[1][1], 32'hCAFEF00D);
      g1 = -1; g2 = -1;
      req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 32'h54;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (gnt[1][1]) begin
            if (g1 < 0) g1 = i;
            else if (g2 < 0) g2 = i;
         end
         if (done[1][1] && (g2 >= 0)) begin
            req[1][1] = 1'b0;
            break;
         end
      end
      req[1][1] = 1'b0;
      check_word("t6_first_gnt", 1, g1, 32'd1);
      check_word("t6_gnt_spacing", 1, g2 - g1, 32'd5);
      tick();

      // Randomized requesters obeying the handshake, with occasional resets.
      for (int c = 0; c < 800; c++) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 2; r++) begin
               if (req[k][r] && done[k][r]) begin
                  if ($urandom_range(1, 0) == 1) new_req(k, r);
                  else req[k][r] = 1'b0;
               end else if (!req[k][r] && ($urandom_range(3, 0) == 0)) begin
                  new_req(k, r);
               end
            end
            mem_out[k] = $urandom();
         end
         reset = ($urandom_range(59, 0) == 0);
      end
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
